// File: rtl/qspi_access_arbiter.sv
// Two-port arbiter in front of the single QSPI flash master: round-robin in normal
// mode, port 1 exclusive in programmer mode, with a watchdog that aborts stuck commands.
module qspi_access_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int OP_W           = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              programmer_enable_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              rsp0_valid_o,
  output logic              rsp0_err_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              rsp1_valid_o,
  output logic              rsp1_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [OP_W-1:0]   m_op_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_done_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              m_abort_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic elig0, elig1, grant_any, grant_sel, done_ok, time_out;

  assign elig0 = req0_valid_i & ~programmer_enable_i;
  assign elig1 = req1_valid_i;
  // NOTE: ready is combinational from the request, so it is qualified with reset_ni
  // to keep every output low while reset is held.
  assign grant_any = (state == S_IDLE) & reset_ni & (elig0 | elig1);
  assign grant_sel = (elig0 & elig1) ? ~last_grant : elig1;

  assign req0_ready_o = grant_any & ~grant_sel;
  assign req1_ready_o = grant_any & grant_sel;
  assign m_valid_o    = (state == S_ISSUE);

  // Completion takes priority over a watchdog expiry landing on the same cycle.
  assign done_ok  = (state == S_WAIT) & m_done_i;
  assign time_out = ((state == S_ISSUE) | (state == S_WAIT)) & (cnt == CNT_LAST) & ~done_ok;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      m_op_o       <= '0;
      m_addr_o     <= '0;
      m_wdata_o    <= '0;
      m_abort_o    <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp0_err_o   <= 1'b0;
      rsp1_err_o   <= 1'b0;
      rsp_rdata_o  <= '0;
    end else begin
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      m_abort_o    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            m_op_o     <= grant_sel ? req1_op_i    : req0_op_i;
            m_addr_o   <= grant_sel ? req1_addr_i  : req0_addr_i;
            m_wdata_o  <= grant_sel ? req1_wdata_i : req0_wdata_i;
            cnt        <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (time_out)       state <= S_RESP;
          else if (m_ready_i) state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (done_ok | time_out) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (done_ok | time_out) begin
        rsp_rdata_o <= time_out ? '0 : m_rdata_i;
        m_abort_o   <= time_out;
        if (owner) begin
          rsp1_valid_o <= 1'b1;
          rsp1_err_o   <= time_out;
        end else begin
          rsp0_valid_o <= 1'b1;
          rsp0_err_o   <= time_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_access_arbiter.sv
// Directed bench for qspi_access_arbiter: reset, round-robin, programmer mode,
// single read, watchdog abort, done-on-boundary and reset during WAIT.
module tb_qspi_access_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        programmer_enable_i;
  logic        req0_valid_i, req0_ready_o, rsp0_valid_o, rsp0_err_o;
  logic [1:0]  req0_op_i;
  logic [23:0] req0_addr_i;
  logic [31:0] req0_wdata_i;
  logic        req1_valid_i, req1_ready_o, rsp1_valid_o, rsp1_err_o;
  logic [1:0]  req1_op_i;
  logic [23:0] req1_addr_i;
  logic [31:0] req1_wdata_i;
  logic [31:0] rsp_rdata_o;
  logic        m_valid_o, m_ready_i, m_done_i, m_abort_o;
  logic [1:0]  m_op_o;
  logic [23:0] m_addr_o;
  logic [31:0] m_wdata_o, m_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  qspi_access_arbiter #(
    .ADDR_W(24), .DATA_W(32), .TIMEOUT_CYCLES(16), .OP_W(2)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .programmer_enable_i(programmer_enable_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_err_o(rsp1_err_o),
    .rsp_rdata_o(rsp_rdata_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_op_o(m_op_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_done_i(m_done_i),
    .m_rdata_i(m_rdata_i), .m_abort_o(m_abort_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":req0_ready"}, req0_ready_o, 0);
    check({tag, ":req1_ready"}, req1_ready_o, 0);
    check({tag, ":rsp0_valid"}, rsp0_valid_o, 0);
    check({tag, ":rsp1_valid"}, rsp1_valid_o, 0);
    check({tag, ":rsp0_err"},   rsp0_err_o,   0);
    check({tag, ":rsp1_err"},   rsp1_err_o,   0);
    check({tag, ":rsp_rdata"},  rsp_rdata_o,  0);
    check({tag, ":m_valid"},    m_valid_o,    0);
    check({tag, ":m_op"},       m_op_o,       0);
    check({tag, ":m_addr"},     m_addr_o,     0);
    check({tag, ":m_wdata"},    m_wdata_o,    0);
    check({tag, ":m_abort"},    m_abort_o,    0);
  endtask

  // One back-to-back transaction with m_ready_i and m_done_i held high:
  // accept, ISSUE, WAIT, RESP. Called on an IDLE cycle with requests already driven.
  task automatic fast_txn(input int port, input logic [31:0] rd, input logic [23:0] addr,
                          input string tag);
    m_rdata_i = rd;
    #1;
    check({tag, ":accept_ready0"}, req0_ready_o, (port == 0));
    check({tag, ":accept_ready1"}, req1_ready_o, (port == 1));
    tick(); #1;
    check({tag, ":issue_valid"}, m_valid_o, 1);
    check({tag, ":issue_addr"},  m_addr_o,  addr);
    check({tag, ":issue_ready"}, {req0_ready_o, req1_ready_o}, 0);
    tick(); #1;
    check({tag, ":wait_valid"}, m_valid_o, 0);
    check({tag, ":wait_rsp"},   {rsp0_valid_o, rsp1_valid_o}, 0);
    tick(); #1;
    check({tag, ":rsp0_valid"}, rsp0_valid_o, (port == 0));
    check({tag, ":rsp1_valid"}, rsp1_valid_o, (port == 1));
    check({tag, ":rdata"},      rsp_rdata_o,  rd);
    check({tag, ":err"},        (port == 1) ? rsp1_err_o : rsp0_err_o, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_ni = 1'b0;
    programmer_enable_i = 1'b0;
    req0_valid_i = 1'b1; req0_op_i = 2'd0; req0_addr_i = 24'h111111; req0_wdata_i = 32'h0000_1111;
    req1_valid_i = 1'b1; req1_op_i = 2'd1; req1_addr_i = 24'h222222; req1_wdata_i = 32'h0000_2222;
    m_ready_i = 1'b1; m_done_i = 1'b1; m_rdata_i = 32'h0;

    // Reset held with requests pending: everything stays low.
    tick(); #1;
    check_all_zero("reset");

    // Round-robin from reset: port 0 first, then alternating.
    tick();
    reset_ni = 1'b1;
    for (int k = 0; k < 4; k++)
      fast_txn(k % 2, 32'hA000_0000 + 32'(k), (k % 2 == 1) ? 24'h222222 : 24'h111111, "rr");

    // Programmer mode: port 1 only, port 0 stalled.
    programmer_enable_i = 1'b1;
    for (int k = 0; k < 3; k++)
      fast_txn(1, 32'hB000_0000 + 32'(k), 24'h222222, "prog");
    programmer_enable_i = 1'b0;
    fast_txn(0, 32'hB000_0010, 24'h111111, "prog_off");

    // Single read, done ignored in ISSUE, done after 5 WAIT cycles.
    req1_valid_i = 1'b0;
    req0_op_i = 2'd0; req0_addr_i = 24'h000100;
    #1;
    check("rd:accept", req0_ready_o, 1);
    tick();
    req0_valid_i = 1'b0;
    #1;
    check("rd:issue_valid", m_valid_o, 1);
    check("rd:issue_addr",  m_addr_o,  24'h000100);
    check("rd:issue_op",    m_op_o,    0);
    tick();
    m_ready_i = 1'b0; m_done_i = 1'b0;
    #1;
    check("rd:done_in_issue_ignored", rsp0_valid_o, 0);
    check("rd:wait_valid", m_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rd:wait_no_rsp", rsp0_valid_o, 0);
    end
    tick();
    m_done_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
    tick();
    m_done_i = 1'b0; m_rdata_i = 32'h0;
    #1;
    check("rd:rsp0_valid", rsp0_valid_o, 1);
    check("rd:rsp1_valid", rsp1_valid_o, 0);
    check("rd:rdata",      rsp_rdata_o,  32'hDEADBEEF);
    check("rd:err",        rsp0_err_o,   0);
    check("rd:abort",      m_abort_o,    0);
    tick(); #1;
    check("rd:rsp_one_cycle", rsp0_valid_o, 0);
    check("rd:rdata_hold",    rsp_rdata_o,  32'hDEADBEEF);

    // Watchdog: master stalls 3 cycles in ISSUE, then never completes.
    req0_valid_i = 1'b1; req0_op_i = 2'd1; req0_addr_i = 24'h00ABCD; req0_wdata_i = 32'h12345678;
    #1;
    check("to:accept", req0_ready_o, 1);
    tick();
    req0_valid_i = 1'b0; req0_addr_i = 24'hFFFFFF;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      m_ready_i = (c == 4);
      #1;
      check("to:no_early_abort", m_abort_o, 0);
      check("to:m_valid", m_valid_o, (c <= 4));
      if (c == 4) begin
        check("to:addr_stable",  m_addr_o,  24'h00ABCD);
        check("to:wdata_stable", m_wdata_o, 32'h12345678);
        check("to:op_stable",    m_op_o,    1);
      end
    end
    tick();
    m_ready_i = 1'b0;
    #1;
    check("to:abort",      m_abort_o,    1);
    check("to:rsp0_valid", rsp0_valid_o, 1);
    check("to:err",        rsp0_err_o,   1);
    check("to:rdata",      rsp_rdata_o,  0);
    check("to:m_valid",    m_valid_o,    0);
    tick(); #1;
    check("to:abort_pulse", m_abort_o,    0);
    check("to:rsp_cleared", rsp0_valid_o, 0);
    check("to:err_hold",    rsp0_err_o,   1);

    // Completion on the last counter value wins over the watchdog.
    req0_valid_i = 1'b1; req0_op_i = 2'd3; req0_addr_i = 24'h000010;
    m_rdata_i = 32'h5A5A5A5A;
    #1;
    check("bd:accept", req0_ready_o, 1);
    tick();
    req0_valid_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      m_ready_i = (c == 1);
      m_done_i  = (c == 16);
      #1;
      check("bd:no_abort", m_abort_o, 0);
    end
    tick();
    m_done_i = 1'b0;
    #1;
    check("bd:rsp0_valid", rsp0_valid_o, 1);
    check("bd:err",        rsp0_err_o,   0);
    check("bd:rdata",      rsp_rdata_o,  32'h5A5A5A5A);
    check("bd:abort",      m_abort_o,    0);
    tick(); #1;
    check("bd:abort_after", m_abort_o, 0);

    // Reset while waiting on the master.
    req0_valid_i = 1'b1; req0_op_i = 2'd0; req0_addr_i = 24'h000200;
    m_ready_i = 1'b1; m_done_i = 1'b0;
    #1;
    check("rst:accept", req0_ready_o, 1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    reset_ni = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    check_all_zero("rst_wait");
    tick(); #1;
    check_all_zero("rst_hold");
    tick();
    reset_ni = 1'b1;
    req0_addr_i = 24'h000300;
    m_done_i = 1'b1;
    fast_txn(0, 32'hC0FFEE00, 24'h000300, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
